// File: rtl/cw305_dbg_reg_bank_if.sv
// Register-bus bundle between cw305_usb_reg_fe (master) and a register bank (slave).
// reg_write is a one-cycle strobe with no back-pressure; reg_datai is valid one cycle after reg_address/reg_bytecnt.
interface cw305_dbg_reg_bank_if #(
  parameter int pADDR_WIDTH   = 14,
  parameter int pBYTECNT_SIZE = 7
);
  logic [pADDR_WIDTH-1:0]   reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic                     reg_write;
  logic [7:0]               reg_datao;
  logic [7:0]               reg_datai;

  modport master (
    output reg_address,
    output reg_bytecnt,
    output reg_write,
    output reg_datao,
    input  reg_datai
  );

  modport slave (
    input  reg_address,
    input  reg_bytecnt,
    input  reg_write,
    input  reg_datao,
    output reg_datai
  );
endinterface

// File: rtl/cw305_dbg_reg_bank.sv
// Debug register bank: timed pulses, level control, synchronised status with sticky flags and edge counters.
// Optional CW305_DBG_TIMESTAMP_EN adds a channel-0 edge timestamp at address 6.
module cw305_dbg_reg_bank #(
  parameter int         pADDR_WIDTH   = 14,
  parameter int         pBYTECNT_SIZE = 7,
  parameter int         pNUM_CH       = 4,
  parameter int         pNUM_PULSE    = 2,
  parameter int         pPULSE_LEN    = 8,
  parameter int         pCNT_WIDTH    = 16,
  parameter logic [7:0] pLEVEL_RST    = 8'h00
) (
  input  logic                  usb_clk,
  input  logic                  rst,
  cw305_dbg_reg_bank_if.slave   bus,
  input  logic [pNUM_CH-1:0]    status_in,
  output logic [pNUM_PULSE-1:0] ctrl_pulse,
  output logic [7:0]            ctrl_level,
  output logic                  irq_any
);

  localparam int CNT_BYTES = pCNT_WIDTH / 8;
  localparam int PW        = $clog2(pPULSE_LEN + 1);

  localparam logic [pADDR_WIDTH-1:0] ADDR_PULSE  = pADDR_WIDTH'(0);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEVEL  = pADDR_WIDTH'(1);
  localparam logic [pADDR_WIDTH-1:0] ADDR_STATUS = pADDR_WIDTH'(2);
  localparam logic [pADDR_WIDTH-1:0] ADDR_STICKY = pADDR_WIDTH'(3);
  localparam logic [pADDR_WIDTH-1:0] ADDR_SEL    = pADDR_WIDTH'(4);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CNT    = pADDR_WIDTH'(5);

  logic byte0;
  logic cnt_byte_ok;
  logic wr_pulse, wr_level, wr_sticky, wr_sel, wr_cnt;

  assign byte0       = (bus.reg_bytecnt == '0);
  assign cnt_byte_ok = (bus.reg_bytecnt < pBYTECNT_SIZE'(CNT_BYTES));
  assign wr_pulse    = bus.reg_write && (bus.reg_address == ADDR_PULSE)  && byte0;
  assign wr_level    = bus.reg_write && (bus.reg_address == ADDR_LEVEL)  && byte0;
  assign wr_sticky   = bus.reg_write && (bus.reg_address == ADDR_STICKY) && byte0;
  assign wr_sel      = bus.reg_write && (bus.reg_address == ADDR_SEL)    && byte0;
  assign wr_cnt      = bus.reg_write && (bus.reg_address == ADDR_CNT)    && cnt_byte_ok;

  // sync1/sync2 form the synchroniser; sync3 only delays sync2 for edge detection.
  logic [pNUM_CH-1:0] sync1, sync2, sync3, rise;
  assign rise = sync2 & ~sync3;

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= status_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // pulse_cnt holds the cycles still to run after the current one; a write reloads it.
  logic [PW-1:0] pulse_cnt [pNUM_PULSE];

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      ctrl_pulse <= '0;
      for (int i = 0; i < pNUM_PULSE; i++) pulse_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < pNUM_PULSE; i++) begin
        if (wr_pulse && bus.reg_datao[i]) begin
          ctrl_pulse[i] <= 1'b1;
          pulse_cnt[i]  <= PW'(pPULSE_LEN - 1);
        end else if (ctrl_pulse[i]) begin
          if (pulse_cnt[i] == '0) ctrl_pulse[i] <= 1'b0;
          else                    pulse_cnt[i]  <= pulse_cnt[i] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge usb_clk) begin
    if (rst) ctrl_level <= pLEVEL_RST;
    else if (wr_level) ctrl_level <= bus.reg_datao;
  end

  // A new edge is OR-ed in after the clear so a simultaneous edge keeps the flag set.
  logic [pNUM_CH-1:0] sticky;
  logic [pNUM_CH-1:0] sticky_clr;
  assign sticky_clr = wr_sticky ? bus.reg_datao[pNUM_CH-1:0] : '0;

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      sticky  <= '0;
      irq_any <= 1'b0;
    end else begin
      sticky  <= (sticky & ~sticky_clr) | rise;
      irq_any <= |sticky;
    end
  end

  logic [pCNT_WIDTH-1:0] edge_cnt [pNUM_CH];
  logic [2:0]            cnt_sel;
  logic                  snap_pend;
  logic [pCNT_WIDTH-1:0] snapshot;
  logic [pCNT_WIDTH-1:0] sel_cnt;

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < pNUM_CH; i++)
      if (cnt_sel == 3'(i)) sel_cnt = edge_cnt[i];
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      for (int i = 0; i < pNUM_CH; i++) edge_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < pNUM_CH; i++) begin
        if (wr_cnt && (cnt_sel == 3'(i)))
          edge_cnt[i] <= rise[i] ? pCNT_WIDTH'(1) : '0;
        else if (rise[i] && (edge_cnt[i] != '1))
          edge_cnt[i] <= edge_cnt[i] + pCNT_WIDTH'(1);
      end
    end
  end

  // Snapshot is taken the cycle after the select write so the host reads all bytes from one instant.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      cnt_sel   <= '0;
      snap_pend <= 1'b0;
      snapshot  <= '0;
    end else begin
      snap_pend <= wr_sel;
      if (wr_sel)    cnt_sel  <= bus.reg_datao[2:0];
      if (snap_pend) snapshot <= sel_cnt;
    end
  end

`ifdef CW305_DBG_TIMESTAMP_EN
  localparam logic [pADDR_WIDTH-1:0] ADDR_TS = pADDR_WIDTH'(6);

  logic        wr_ts;
  logic [31:0] ts_cnt;
  logic [31:0] ts_latch;

  assign wr_ts = bus.reg_write && (bus.reg_address == ADDR_TS) &&
                 (bus.reg_bytecnt < pBYTECNT_SIZE'(4));

  // Latched value is the cycle in which the edge becomes visible in STICKY, hence the +1.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      ts_cnt   <= '0;
      ts_latch <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (rise[0])    ts_latch <= ts_cnt + 32'd1;
      else if (wr_ts) ts_latch <= '0;
    end
  end
`endif

  logic [7:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (bus.reg_address)
      ADDR_LEVEL:  if (byte0) rd_data = ctrl_level;
      ADDR_STATUS: if (byte0) rd_data = 8'(sync2);
      ADDR_STICKY: if (byte0) rd_data = 8'(sticky);
      ADDR_SEL:    if (byte0) rd_data = {5'b0, cnt_sel};
      ADDR_CNT: begin
        for (int b = 0; b < CNT_BYTES; b++)
          if (bus.reg_bytecnt == pBYTECNT_SIZE'(b)) rd_data = snapshot[b*8 +: 8];
      end
`ifdef CW305_DBG_TIMESTAMP_EN
      ADDR_TS: begin
        for (int b = 0; b < 4; b++)
          if (bus.reg_bytecnt == pBYTECNT_SIZE'(b)) rd_data = ts_latch[b*8 +: 8];
      end
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (rst) bus.reg_datai <= '0;
    else     bus.reg_datai <= rd_data;
  end

endmodule

// File: tb/tb_cw305_dbg_reg_bank.sv
// Bench for cw305_dbg_reg_bank: a 16-bit-counter instance (a) and an 8-bit-counter instance (b) share all stimulus.
// Expected responses go into a queue; a monitor pops and compares one cycle phase later.
module tb_cw305_dbg_reg_bank;
  localparam int AW = 14;
  localparam int BW = 7;

  localparam int K_RD_A  = 0;
  localparam int K_RD_B  = 1;
  localparam int K_PULSE = 2;
  localparam int K_IRQ   = 3;
  localparam int K_LEVEL = 4;

  logic       usb_clk;
  logic       rst;
  logic [3:0] status_in;
  logic [1:0] pulse_a, pulse_b;
  logic [7:0] level_a, level_b;
  logic       irq_a, irq_b;

  cw305_dbg_reg_bank_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) bus_a ();
  cw305_dbg_reg_bank_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) bus_b ();

  assign bus_b.reg_address = bus_a.reg_address;
  assign bus_b.reg_bytecnt = bus_a.reg_bytecnt;
  assign bus_b.reg_write   = bus_a.reg_write;
  assign bus_b.reg_datao   = bus_a.reg_datao;

  cw305_dbg_reg_bank #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW), .pCNT_WIDTH(16)) dut_a (
    .usb_clk(usb_clk), .rst(rst), .bus(bus_a), .status_in(status_in),
    .ctrl_pulse(pulse_a), .ctrl_level(level_a), .irq_any(irq_a)
  );

  cw305_dbg_reg_bank #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW), .pCNT_WIDTH(8)) dut_b (
    .usb_clk(usb_clk), .rst(rst), .bus(bus_b), .status_in(status_in),
    .ctrl_pulse(pulse_b), .ctrl_level(level_b), .irq_any(irq_b)
  );

  // clock / reset
  initial begin
    usb_clk = 1'b0;
    forever #5 usb_clk = ~usb_clk;
  end

`ifdef CW305_DBG_TIMESTAMP_EN
  logic [31:0] cyc;
  always @(posedge usb_clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end
`endif

  // scoreboard
  logic [7:0] exp_q[$];
  int         kind_q[$];
  string      name_q[$];
  int         checks = 0;
  int         passes = 0;

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  initial begin
    forever begin
      @(negedge usb_clk);
      #1;
      while (exp_q.size() > 0) begin
        logic [7:0] e, act;
        int         k;
        string      n;
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_RD_A:  act = bus_a.reg_datai;
          K_RD_B:  act = bus_b.reg_datai;
          K_PULSE: act = {6'b0, pulse_a};
          K_IRQ:   act = {7'b0, irq_a};
          default: act = level_a;
        endcase
        checks++;
        if (act === e) passes++;
        else $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge usb_clk);
  endtask

  task automatic wr(input int addr, input int bc, input logic [7:0] d);
    bus_a.reg_address = AW'(addr);
    bus_a.reg_bytecnt = BW'(bc);
    bus_a.reg_datao   = d;
    bus_a.reg_write   = 1'b1;
    @(negedge usb_clk);
    bus_a.reg_write   = 1'b0;
  endtask

  task automatic rd(input int kind, input int addr, input int bc, input logic [7:0] exp, input string name);
    bus_a.reg_address = AW'(addr);
    bus_a.reg_bytecnt = BW'(bc);
    @(posedge usb_clk);
    push(kind, exp, name);
    @(negedge usb_clk);
  endtask

  task automatic chk(input int kind, input logic [7:0] exp, input string name);
    push(kind, exp, name);
  endtask

  task automatic edge_ch(input int ch);
    status_in[ch] = 1'b1;
    tick(1);
    status_in[ch] = 1'b0;
    tick(1);
  endtask

  task automatic sel(input int ch);
    wr(4, 0, 8'(ch));
    tick(1);
  endtask

  initial begin
    rst               = 1'b1;
    status_in         = '0;
    bus_a.reg_address = '0;
    bus_a.reg_bytecnt = '0;
    bus_a.reg_write   = 1'b0;
    bus_a.reg_datao   = '0;
    repeat (2) @(posedge usb_clk);
    @(negedge usb_clk);
    rst = 1'b0;

    // reset state
    chk(K_LEVEL, 8'h00, "rst_level");
    chk(K_PULSE, 8'h00, "rst_pulse");
    chk(K_IRQ,   8'h00, "rst_irq");
    rd(K_RD_A, 2, 0, 8'h00, "rst_status");
    rd(K_RD_A, 3, 0, 8'h00, "rst_sticky");
    rd(K_RD_A, 4, 0, 8'h00, "rst_cnt_sel");

    // level register, byte 1 ignored
    wr(1, 0, 8'hA5);
    chk(K_LEVEL, 8'hA5, "level_out");
    rd(K_RD_A, 1, 0, 8'hA5, "level_rd");
    wr(1, 1, 8'hFF);
    rd(K_RD_A, 1, 0, 8'hA5, "level_byte1_wr_ignored");
    rd(K_RD_A, 1, 1, 8'h00, "level_byte1_rd");

    // pulse retrigger: 5 + 8 = 13 cycles high
    wr(0, 0, 8'h01);
    for (int c = 1; c <= 5; c++) begin
      chk(K_PULSE, 8'h01, $sformatf("pulse_c%0d", c));
      if (c < 5) tick(1);
    end
    wr(0, 0, 8'h01);
    for (int c = 6; c <= 14; c++) begin
      chk(K_PULSE, (c <= 13) ? 8'h01 : 8'h00, $sformatf("pulse_c%0d", c));
      tick(1);
    end
    wr(0, 0, 8'h82);
    chk(K_PULSE, 8'h02, "pulse1_high_bit7_ignored");
    tick(8);
    chk(K_PULSE, 8'h00, "pulse1_done");

    // sticky / irq
    edge_ch(2);
    tick(3);
    chk(K_IRQ, 8'h01, "irq_set");
    rd(K_RD_A, 3, 0, 8'h04, "sticky_set");
    rd(K_RD_A, 2, 0, 8'h00, "status_after_pulse");
    wr(3, 0, 8'h00);
    rd(K_RD_A, 3, 0, 8'h04, "sticky_w0_keeps");
    status_in[2] = 1'b1;
    tick(1);
    status_in[2] = 1'b0;
    tick(1);
    wr(3, 0, 8'h04);
    rd(K_RD_A, 3, 0, 8'h04, "sticky_set_wins");
    wr(3, 0, 8'h04);
    chk(K_IRQ, 8'h01, "irq_lag");
    tick(1);
    chk(K_IRQ, 8'h00, "irq_cleared");
    rd(K_RD_A, 3, 0, 8'h00, "sticky_cleared");

    // ch2 saw two edges
    sel(2);
    rd(K_RD_A, 5, 0, 8'h02, "cnt_ch2_b0");
    rd(K_RD_A, 5, 1, 8'h00, "cnt_ch2_b1");

    // saturation on ch1: 300 = 0x012C, 8-bit instance saturates at FF
    for (int i = 0; i < 300; i++) edge_ch(1);
    tick(2);
    sel(1);
    rd(K_RD_B, 5, 0, 8'hFF, "sat_b_b0");
    rd(K_RD_A, 5, 0, 8'h2C, "cnt300_a_b0");
    rd(K_RD_A, 5, 1, 8'h01, "cnt300_a_b1");
    wr(5, 0, 8'h00);
    tick(1);
    sel(1);
    rd(K_RD_B, 5, 0, 8'h00, "clr_b");
    rd(K_RD_A, 5, 1, 8'h00, "clr_a_b1");
    edge_ch(1);
    edge_ch(1);
    tick(2);
    sel(1);
    rd(K_RD_B, 5, 0, 8'h02, "recount_b");
    status_in[1] = 1'b1;
    tick(1);
    status_in[1] = 1'b0;
    tick(1);
    wr(5, 0, 8'h00);
    tick(2);
    sel(1);
    rd(K_RD_B, 5, 0, 8'h01, "clr_edge_b");
    rd(K_RD_A, 5, 0, 8'h01, "clr_edge_a");

    // coherent snapshot on ch3: 258 = 0x0102
    for (int i = 0; i < 258; i++) edge_ch(3);
    tick(2);
    sel(3);
    for (int i = 0; i < 5; i++) edge_ch(3);
    tick(2);
    rd(K_RD_A, 5, 0, 8'h02, "snap_a_b0");
    rd(K_RD_A, 5, 1, 8'h01, "snap_a_b1");
    rd(K_RD_A, 5, 2, 8'h00, "snap_a_b2_beyond");
    rd(K_RD_B, 5, 0, 8'hFF, "snap_b_b0");
    rd(K_RD_B, 5, 1, 8'h00, "snap_b_b1_beyond");
    rd(K_RD_A, 9, 0, 8'h00, "unmapped_9");
    rd(K_RD_A, 4, 0, 8'h03, "cnt_sel_rd");
    sel(5);
    rd(K_RD_A, 5, 0, 8'h00, "snap_out_of_range");
    rd(K_RD_A, 4, 0, 8'h05, "cnt_sel_5");

    // status level and channel-0 timestamp
    begin
`ifdef CW305_DBG_TIMESTAMP_EN
      logic [31:0] exp_ts;
      exp_ts = cyc + 32'd3;
`endif
      status_in[0] = 1'b1;
      tick(2);
      rd(K_RD_A, 2, 0, 8'h01, "status_level");
`ifdef CW305_DBG_TIMESTAMP_EN
      rd(K_RD_A, 6, 0, exp_ts[7:0],   "ts_b0");
      rd(K_RD_A, 6, 1, exp_ts[15:8],  "ts_b1");
      rd(K_RD_A, 6, 2, exp_ts[23:16], "ts_b2");
      rd(K_RD_A, 6, 3, exp_ts[31:24], "ts_b3");
      wr(6, 2, 8'h00);
      rd(K_RD_A, 6, 0, 8'h00, "ts_cleared");
`else
      rd(K_RD_A, 6, 0, 8'h00, "ts_absent");
`endif
    end

    tick(2);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
